pwm_led_ctrl: RTL and testbench

//  Parametrised soft-PWM LED controller on the 6502 register bus. Next generation
//  of the ice40 RGB driver: NCH channels, programmable PWM width, prescaler,

---
 rtl/pwm_led_pkg.sv | 26 ++
 rtl/pwm_led_chan.sv | 115 +++++++++++
 rtl/pwm_led_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pwm_led_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_led_pkg.sv
// Shared definitions for the soft-PWM LED controller: register map,
// channel mode encodings and the blink/breathe state encodings.
package pwm_led_pkg;

    localparam logic [4:0] ADDR_CTRL    = 5'h00;
    localparam logic [4:0] ADDR_PRE_LO  = 5'h01;
    localparam logic [4:0] ADDR_PRE_HI  = 5'h02;
    localparam logic [4:0] ADDR_BLK_ON  = 5'h03;
    localparam logic [4:0] ADDR_BLK_OFF = 5'h04;
    localparam logic [4:0] ADDR_STAT    = 5'h05;
    localparam int         CHAN_BASE    = 8;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_OUT_EN = 1;
    localparam int CTRL_INVERT = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam logic [1:0] MODE_STATIC     = 2'd0;
    localparam logic [1:0] MODE_BLINK      = 2'd1;
    localparam logic [1:0] MODE_BREATHE    = 2'd2;
    localparam logic [1:0] MODE_STATIC_ALT = 2'd3;

    typedef enum logic {BLINK_ON = 1'b0, BLINK_OFF = 1'b1} blink_state_t;
    typedef enum logic {BR_UP = 1'b0, BR_DOWN = 1'b1} breathe_state_t;

endpackage

// File: rtl/pwm_led_chan.sv
// One PWM channel: host-visible duty/mode, frame-aligned shadow copies,
// the per-channel breathe ramp, and the compare + polarity output register.
module pwm_led_chan
    import pwm_led_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             duty_we,
    input  logic             mode_we,
    input  logic [PWM_W-1:0] duty_din,
    input  logic [1:0]       mode_din,
    input  logic             run,
    input  logic             frame,
    input  logic             blink_on,
    input  logic             out_en,
    input  logic             invert,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic [PWM_W-1:0] duty_host,
    output logic [1:0]       mode_host,
    output logic             pwm_out
);

    logic [PWM_W-1:0] duty_sh;
    logic [1:0]       mode_sh;
    breathe_state_t   br_state, br_next;
    logic [PWM_W-1:0] ramp, ramp_next;
    logic [PWM_W:0]   ramp_inc;
    logic [PWM_W-1:0] level;
    logic             breathing;
    logic             raw;

    assign breathing = run && (mode_sh == MODE_BREATHE);
    assign ramp_inc  = {1'b0, ramp} + {{PWM_W{1'b0}}, 1'b1};

    // Host-side duty/mode registers, written directly from the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_host <= '0;
            mode_host <= '0;
        end else begin
            if (duty_we) duty_host <= duty_din;
            if (mode_we) mode_host <= mode_din;
        end
    end

    // Shadow copies only change on a frame boundary (or while stopped, when no frame is in flight).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_sh <= '0;
            mode_sh <= '0;
        end else if (frame || !run) begin
            duty_sh <= duty_host;
            mode_sh <= mode_host;
        end
    end

    // Breathe state register: ramp restarts from 0/UP whenever the channel is not breathing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_state <= BR_UP;
            ramp     <= '0;
        end else if (!breathing) begin
            br_state <= BR_UP;
            ramp     <= '0;
        end else if (frame) begin
            br_state <= br_next;
            ramp     <= ramp_next;
        end
    end

    // Breathe next-state: climb to the duty value, then fall back to zero.
    always_comb begin
        br_next   = br_state;
        ramp_next = ramp;
        case (br_state)
            BR_UP: begin
                if (ramp_inc >= {1'b0, duty_sh}) begin
                    ramp_next = duty_sh;
                    br_next   = BR_DOWN;
                end else begin
                    ramp_next = ramp_inc[PWM_W-1:0];
                end
            end
            BR_DOWN: begin
                if (ramp <= {{(PWM_W-1){1'b0}}, 1'b1}) begin
                    ramp_next = '0;
                    br_next   = BR_UP;
                end else begin
                    ramp_next = ramp - {{(PWM_W-1){1'b0}}, 1'b1};
                end
            end
            default: br_next = BR_UP;
        endcase
    end

    // Output level selection per mode, then the raw compare against the frame counter.
    always_comb begin
        level = duty_sh;
        case (mode_sh)
            MODE_BLINK:   level = blink_on ? duty_sh : '0;
            MODE_BREATHE: level = ramp;
            default:      level = duty_sh;
        endcase
        raw = run && (pwm_cnt < level);
    end

    // Registered pad drive with polarity; disabled outputs rest at the idle polarity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_out <= 1'b0;
        else        pwm_out <= out_en ? (raw ^ invert) : invert;
    end

endmodule

// File: rtl/pwm_led_ctrl.sv
// Soft-PWM LED controller on the 6502 register bus: register decode,
// prescaler, shared PWM counter, shared blink sequencer, frame status/IRQ
// and readback; per-channel work lives in pwm_led_chan.
module pwm_led_ctrl
    import pwm_led_pkg::*;
#(
    parameter int NCH   = 3,
    parameter int PWM_W = 8,
    parameter int PRE_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cs,
    input  logic           we,
    input  logic [4:0]     addr,
    input  logic [7:0]     din,
    output logic [7:0]     dout,
    output logic [NCH-1:0] pwm_out,
    output logic           frame_irq
);

    logic [3:0]       ctrl;
    logic [PRE_W-1:0] pre, pre_cnt;
    logic [15:0]      pre16;
    logic [7:0]       blk_on, blk_off, act_on, act_off;
    logic             stat;
    logic [PWM_W-1:0] pwm_cnt;
    logic             wr, rd, run, tick, frame;
    blink_state_t     blink_state, blink_next;
    logic [7:0]       bcnt, bcnt_next;
    logic [8:0]       bcnt_inc;
    logic             phase_end, blink_on;
    logic [7:0]       rdata;
    logic [PWM_W-1:0] duty_host [NCH];
    logic [1:0]       mode_host [NCH];

    assign wr        = cs && we;
    assign rd        = cs && !we;
    assign run       = ctrl[CTRL_RUN];
    assign pre16     = 16'(pre);
    assign tick      = run && (pre_cnt == pre);
    assign frame     = tick && (pwm_cnt == {PWM_W{1'b1}});
    assign frame_irq = stat && ctrl[CTRL_IRQ_EN];
    assign bcnt_inc  = {1'b0, bcnt} + 9'd1;

    // Global configuration registers written from the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl    <= '0;
            pre     <= '0;
            blk_on  <= '0;
            blk_off <= '0;
        end else if (wr) begin
            case (addr)
                ADDR_CTRL:    ctrl    <= din[3:0];
                ADDR_PRE_LO:  pre     <= PRE_W'({pre16[15:8], din});
                ADDR_PRE_HI:  pre     <= PRE_W'({din, pre16[7:0]});
                ADDR_BLK_ON:  blk_on  <= din;
                ADDR_BLK_OFF: blk_off <= din;
                default: ;
            endcase
        end
    end

    // Sticky frame flag; a frame in the same cycle as a clearing read keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         stat <= 1'b0;
        else if (frame)                     stat <= 1'b1;
        else if (rd && addr == ADDR_STAT)   stat <= 1'b0;
    end

    // Prescaler: one PWM tick every PRE+1 clocks while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              pre_cnt <= '0;
        else if (!run || tick)   pre_cnt <= '0;
        else                     pre_cnt <= pre_cnt + PRE_W'(1);
    end

    // Shared PWM counter, wrapping at the end of each frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pwm_cnt <= '0;
        else if (!run)   pwm_cnt <= '0;
        else if (tick)   pwm_cnt <= pwm_cnt + PWM_W'(1);
    end

    // Blink state register; phase lengths are re-sampled only at phase boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_state <= BLINK_ON;
            bcnt        <= '0;
            act_on      <= '0;
            act_off     <= '0;
        end else if (!run) begin
            blink_state <= BLINK_ON;
            bcnt        <= '0;
            act_on      <= blk_on;
            act_off     <= blk_off;
        end else if (frame) begin
            blink_state <= blink_next;
            bcnt        <= bcnt_next;
            if (phase_end) begin
                act_on  <= blk_on;
                act_off <= blk_off;
            end
        end
    end

    // Blink next-state: count frames in the current phase, switch when it is used up.
    always_comb begin
        blink_next = blink_state;
        bcnt_next  = bcnt_inc[7:0];
        phase_end  = 1'b0;
        case (blink_state)
            BLINK_ON: begin
                if (bcnt_inc >= {1'b0, act_on}) begin
                    phase_end = 1'b1;
                    bcnt_next = '0;
                    if (act_off != 8'd0) blink_next = BLINK_OFF;
                end
            end
            BLINK_OFF: begin
                if (bcnt_inc >= {1'b0, act_off}) begin
                    phase_end = 1'b1;
                    bcnt_next = '0;
                    if (act_on != 8'd0) blink_next = BLINK_ON;
                end
            end
            default: blink_next = BLINK_ON;
        endcase
    end

    // Blink output: a zero ON length means the channel never lights.
    always_comb begin
        blink_on = (blink_state == BLINK_ON) && (act_on != 8'd0);
    end

    // Readback mux; unmapped addresses and absent channels read as zero.
    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:    rdata = {4'b0, ctrl};
            ADDR_PRE_LO:  rdata = pre16[7:0];
            ADDR_PRE_HI:  rdata = pre16[15:8];
            ADDR_BLK_ON:  rdata = blk_on;
            ADDR_BLK_OFF: rdata = blk_off;
            ADDR_STAT:    rdata = {7'b0, stat};
            default: ;
        endcase
        for (int c = 0; c < NCH; c++) begin
            if (addr == 5'(CHAN_BASE + 2 * c))     rdata = 8'(duty_host[c]);
            if (addr == 5'(CHAN_BASE + 2 * c + 1)) rdata = {6'b0, mode_host[c]};
        end
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   dout <= '0;
        else if (rd)  dout <= rdata;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        pwm_led_chan #(.PWM_W(PWM_W)) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .duty_we   (wr && (addr == 5'(CHAN_BASE + 2 * c))),
            .mode_we   (wr && (addr == 5'(CHAN_BASE + 2 * c + 1))),
            .duty_din  (din[PWM_W-1:0]),
            .mode_din  (din[1:0]),
            .run       (run),
            .frame     (frame),
            .blink_on  (blink_on),
            .out_en    (ctrl[CTRL_OUT_EN]),
            .invert    (ctrl[CTRL_INVERT]),
            .pwm_cnt   (pwm_cnt),
            .duty_host (duty_host[c]),
            .mode_host (mode_host[c]),
            .pwm_out   (pwm_out[c])
        );
    end

endmodule

// File: tb/tb_pwm_led_ctrl.sv
// Directed bench for pwm_led_ctrl (NCH=3, PWM_W=8, PRE_W=16, PRE=0 so one
// PWM step per clock and one frame every 256 clocks).
module tb_pwm_led_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    logic [4:0] addr = '0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic [2:0] pwm_out;
    logic       frame_irq;

    int total_cnt = 0;
    int bad_cnt = 0;

    always #5 clk = ~clk;

    pwm_led_ctrl #(.NCH(3), .PWM_W(8), .PRE_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cs),
        .we        (we),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .pwm_out   (pwm_out),
        .frame_irq (frame_irq)
    );

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        total_cnt++;
        if (observed !== expected) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Bus write; called at a falling edge, returns at the next falling edge.
    task automatic applyStimulus(input logic [4:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    // Bus read; dout is registered so it is valid at the next falling edge.
    task automatic readReg(input logic [4:0] a, output int val);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0;
        val = int'(dout);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Number of falling-edge samples within n clocks where a channel is high.
    task automatic countHigh(input int ch, input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            if (pwm_out[ch]) hi++;
        end
    endtask

    int v;
    int hi;
    int found;
    logic prev;
    int blink_exp[6]   = '{64, 64, 0, 0, 0, 64};
    int breathe_exp[8] = '{0, 1, 2, 3, 2, 1, 0, 1};

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_pwm_out", int'(pwm_out), 0);
        checkOutput("rst_dout", int'(dout), 0);
        checkOutput("rst_irq", int'(frame_irq), 0);
        rst_n = 1'b1;
        @(negedge clk);
        readReg(5'h00, v); checkOutput("rst_ctrl", v, 0);
        readReg(5'h03, v); checkOutput("rst_blk_on", v, 0);
        readReg(5'h08, v); checkOutput("rst_duty0", v, 0);
        readReg(5'h05, v); checkOutput("rst_stat", v, 0);

        // register readback and unmapped/absent locations
        applyStimulus(5'h01, 8'h34);
        applyStimulus(5'h02, 8'h12);
        readReg(5'h01, v); checkOutput("pre_lo", v, 8'h34);
        readReg(5'h02, v); checkOutput("pre_hi", v, 8'h12);
        applyStimulus(5'h01, 8'h00);
        applyStimulus(5'h02, 8'h00);
        applyStimulus(5'h08, 8'h40);
        readReg(5'h08, v); checkOutput("duty0_rb", v, 8'h40);
        applyStimulus(5'h09, 8'h07);
        readReg(5'h09, v); checkOutput("mode0_rb", v, 3);
        applyStimulus(5'h09, 8'h00);
        applyStimulus(5'h0E, 8'h55);
        readReg(5'h0E, v); checkOutput("duty3_absent", v, 0);
        applyStimulus(5'h06, 8'hAA);
        readReg(5'h06, v); checkOutput("unmapped", v, 0);

        // stopped, enabled, inverted: output rests at the inverted level
        applyStimulus(5'h00, 8'h06);
        countHigh(0, 16, hi); checkOutput("stopped_invert", hi, 16);

        // static duty
        applyStimulus(5'h00, 8'h03);
        countHigh(0, 256, hi); checkOutput("static_40", hi, 64);
        applyStimulus(5'h08, 8'h00);
        waitCycles(300);
        countHigh(0, 256, hi); checkOutput("static_00", hi, 0);
        applyStimulus(5'h08, 8'hFF);
        waitCycles(300);
        countHigh(0, 256, hi); checkOutput("static_ff", hi, 255);

        // outputs disabled while running: idle polarity only
        applyStimulus(5'h00, 8'h05);
        countHigh(0, 64, hi); checkOutput("out_dis_invert", hi, 64);

        // glitch-free duty update mid-frame
        applyStimulus(5'h00, 8'h03);
        applyStimulus(5'h08, 8'h40);
        waitCycles(300);
        found = 0;
        prev = pwm_out[0];
        for (int i = 0; i < 600 && found == 0; i++) begin
            @(negedge clk);
            if (pwm_out[0] && !prev) found = 1;
            prev = pwm_out[0];
        end
        checkOutput("frame_start_seen", found, 1);
        waitCycles(127);
        applyStimulus(5'h08, 8'hC0);
        countHigh(0, 120, hi); checkOutput("glitch_cur_frame", hi, 0);
        waitCycles(16);
        countHigh(0, 256, hi); checkOutput("glitch_next_frame", hi, 192);

        // blink: 2 frames on, 3 frames off
        applyStimulus(5'h00, 8'h00);
        applyStimulus(5'h03, 8'd2);
        applyStimulus(5'h04, 8'd3);
        applyStimulus(5'h08, 8'h40);
        applyStimulus(5'h09, 8'h01);
        applyStimulus(5'h00, 8'h03);
        for (int f = 0; f < 6; f++) begin
            countHigh(0, 256, hi);
            checkOutput($sformatf("blink_f%0d", f), hi, blink_exp[f]);
        end

        // blink with zero OFF length stays on
        applyStimulus(5'h00, 8'h00);
        applyStimulus(5'h04, 8'd0);
        applyStimulus(5'h00, 8'h03);
        for (int f = 0; f < 4; f++) begin
            countHigh(0, 256, hi);
            checkOutput($sformatf("blink_cont_f%0d", f), hi, 64);
        end

        // breathe on channel 1 with duty 3
        applyStimulus(5'h00, 8'h00);
        applyStimulus(5'h09, 8'h00);
        applyStimulus(5'h0A, 8'd3);
        applyStimulus(5'h0B, 8'h02);
        applyStimulus(5'h00, 8'h03);
        for (int f = 0; f < 8; f++) begin
            countHigh(1, 256, hi);
            checkOutput($sformatf("breathe_f%0d", f), hi, breathe_exp[f]);
        end
        applyStimulus(5'h00, 8'h00);
        applyStimulus(5'h00, 8'h07);
        for (int f = 0; f < 4; f++) begin
            countHigh(1, 256, hi);
            checkOutput($sformatf("breathe_inv_f%0d", f), hi, 256 - breathe_exp[f]);
        end

        // frame status and interrupt
        applyStimulus(5'h00, 8'h00);
        readReg(5'h05, v); checkOutput("stat_sticky", v, 1);
        readReg(5'h05, v); checkOutput("stat_cleared", v, 0);
        applyStimulus(5'h00, 8'h0B);
        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            @(negedge clk);
            if (frame_irq) found = 1;
        end
        checkOutput("irq_seen", found, 1);
        readReg(5'h05, v); checkOutput("stat_after_frame", v, 1);
        checkOutput("irq_after_clear", int'(frame_irq), 0);
        waitCycles(254);
        readReg(5'h05, v); checkOutput("stat_read_on_frame", v, 0);
        checkOutput("irq_set_wins", int'(frame_irq), 1);
        readReg(5'h05, v); checkOutput("stat_next_read", v, 1);
        checkOutput("irq_next_clear", int'(frame_irq), 0);

        // asynchronous reset in the middle of a run
        waitCycles(300);
        checkOutput("irq_before_reset", int'(frame_irq), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_pwm_out", int'(pwm_out), 0);
        checkOutput("mid_rst_dout", int'(dout), 0);
        checkOutput("mid_rst_irq", int'(frame_irq), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        readReg(5'h00, v); checkOutput("post_rst_ctrl", v, 0);
        readReg(5'h08, v); checkOutput("post_rst_duty0", v, 0);
        readReg(5'h05, v); checkOutput("post_rst_stat", v, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    // Hard bound on run time in case the stimulus ever stalls.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
